// File: rtl/uart_receiver.sv
// UART receive stage: 2-FF synchronized rxd, 16x oversampled mid-bit sampling, holding register with status.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_error output.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 receive_baud,
  output logic                 receive_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_read,
  output logic                 framing_error,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_nxt;
  logic                 sync1, sync2, prev;
  logic                 fall;
  logic                 start_nxt;
  logic                 capture;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit, parity_bit_nxt;
`endif

  // NOTE: the synchronizer resets to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall = prev & ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      receive_start <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      tick_cnt      <= tick_cnt_nxt;
      bit_cnt       <= bit_cnt_nxt;
      shift         <= shift_nxt;
      receive_start <= start_nxt;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= parity_bit_nxt;
`endif
    end
  end

  // NOTE: every signal gets its default before the case so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    start_nxt    = 1'b0;
    capture      = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_nxt = parity_bit;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          start_nxt    = 1'b1;
          tick_cnt_nxt = '0;
          state_nxt    = START;
        end
      end
      START: begin
        if (receive_baud) begin
          if (tick_cnt == HALF_TICK) begin
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            state_nxt    = sync2 ? IDLE : DATA;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (receive_baud) begin
          tick_cnt_nxt = tick_cnt + 1'b1;
          if (tick_cnt == LAST_TICK) begin
            shift_nxt = {sync2, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
              state_nxt   = PARITY;
`else
              state_nxt   = STOP;
`endif
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (receive_baud) begin
          tick_cnt_nxt = tick_cnt + 1'b1;
          if (tick_cnt == LAST_TICK) begin
            parity_bit_nxt = sync2;
            state_nxt      = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (receive_baud) begin
          tick_cnt_nxt = tick_cnt + 1'b1;
          if (tick_cnt == LAST_TICK) begin
            capture   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture takes priority over a same-cycle rx_read, so the fresh byte is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else if (capture) begin
      rx_data       <= shift;
      rx_valid      <= 1'b1;
      framing_error <= ~sync2;
      overrun       <= ~rx_read & (overrun | rx_valid);
`ifdef UART_RX_PARITY_EN
      parity_error  <= ^{shift, parity_bit};
`endif
    end else if (rx_read) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of framed bytes plus directed multi-cycle corner cases.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int CAPTURE_TICK = 8 + 16 * 8 + 16 + 16;
`else
  localparam int CAPTURE_TICK = 8 + 16 * 8 + 16;
`endif

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       receive_baud;
  logic       receive_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read;
  logic       framing_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  int start_cnt = 0;

  uart_receiver dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd           (rxd),
    .receive_baud  (receive_baud),
    .receive_start (receive_start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_read       (rx_read),
    .framing_error (framing_error),
    .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error  (parity_error)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk oversample tick every 4 clk.
  initial begin
    receive_baud = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 receive_baud = 1'b1;
      @(posedge clk);
      #1 receive_baud = 1'b0;
    end
  end

  always @(posedge clk) if (receive_start) start_cnt <= start_cnt + 1;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    logic       read_before;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_fe;
    logic       exp_ovr;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic wait_bit();
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    rx_read = 1'b1;
    @(posedge clk);
    #1 rx_read = 1'b0;
  endtask

  // Called and returns at posedge+1. One idle bit first guarantees a fresh falling edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input bit chk_start);
    rxd = 1'b1;
    wait_bit();
    rxd = 1'b0;
    if (chk_start) begin
      repeat (2) @(posedge clk);
      #1 check("start_early", receive_start, 1'b0);
      @(posedge clk);
      #1 check("start_pulse", receive_start, 1'b1);
      @(posedge clk);
      #1 check("start_width", receive_start, 1'b0);
      repeat (BIT_CLKS - 4) @(posedge clk);
      #1;
    end else begin
      wait_bit();
    end
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_bit();
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    wait_bit();
`else
    if (par) rxd = 1'b1;
`endif
    rxd = stop;
    wait_bit();
  endtask

  // Raises rx_read for exactly the clk edge of the stop-bit capture tick.
  task automatic read_at_capture();
    int n = 0;
    int waited = 0;
    while (!receive_start && waited < 400) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (!receive_start) begin
      check_cnt++;
      $display("FAIL start_wait: receive_start not seen within 400 cycles");
      return;
    end
    while (n < CAPTURE_TICK) begin
      if (receive_baud) n++;
      if (n == CAPTURE_TICK) rx_read = 1'b1;
      @(posedge clk);
      #2;
    end
    rx_read = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic v,
                               input logic fe, input logic ov, input logic pe);
    check({tag, "_data"}, rx_data, d);
    check({tag, "_valid"}, rx_valid, v);
    check({tag, "_fe"}, framing_error, fe);
    check({tag, "_ovr"}, overrun, ov);
`ifdef UART_RX_PARITY_EN
    check({tag, "_pe"}, parity_error, pe);
`else
    if (pe) check({tag, "_start_idle"}, receive_start, 1'b0);
`endif
  endtask

  initial begin
    int c0;
    //          data   stop  par   rd    exp   v     fe    ov    pe
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n   = 1'b0;
    rxd     = 1'b1;
    rx_read = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_start", receive_start, 1'b0);
    check_outputs("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    wait_bit();

    // False start: low for 3 ticks only.
    c0  = start_cnt;
    rxd = 1'b0;
    repeat (12) @(posedge clk);
    #1 rxd = 1'b1;
    wait_bit();
    wait_bit();
    check("false_start_pulses", start_cnt - c0, 1);
    check("false_start_valid", rx_valid, 1'b0);
    check("false_start_data", rx_data, 8'h00);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].read_before) pulse_read();
      c0 = start_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par, 1'b1);
      check($sformatf("vec%0d_pulses", i), start_cnt - c0, 1);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                    vecs[i].exp_fe, vecs[i].exp_ovr, vecs[i].exp_pe);
    end

    // rx_read clears valid and overrun, data and error flags persist.
    pulse_read();
    check_outputs("read_clear", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);

    // Framing error with the line left low: no restart until a fresh edge.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check_outputs("fe_low", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    c0 = start_cnt;
    repeat (4) wait_bit();
    check("held_low_no_start", start_cnt - c0, 0);
    check("held_low_valid", rx_valid, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    check("after_low_pulses", start_cnt - c0, 1);
    check_outputs("after_low", 8'h81, 1'b1, 1'b0, 1'b1, 1'b0);

    // rx_read on the capture cycle: capture wins, no overrun.
    fork
      send_frame(8'h42, 1'b1, 1'b0, 1'b0);
      read_at_capture();
    join
    check_outputs("read_on_capture", 8'h42, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during data bit 4 discards the partial byte.
    rxd = 1'b1;
    wait_bit();
    rxd = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      rxd = (8'hC3 >> i) & 8'h01;
      wait_bit();
    end
    rxd = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrst_start", receive_start, 1'b0);
    check_outputs("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rxd = 1'b1;
    wait_bit();
    wait_bit();
    check("post_rst_valid", rx_valid, 1'b0);
    c0 = start_cnt;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    check("post_rst_pulses", start_cnt - c0, 1);
    check_outputs("post_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
